div_issue: RTL and testbench



---
 rtl/div_issue.sv | 152 +++++++++++++++
 tb/tb_div_issue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue.sv
`timescale 1ns/1ps
// div_issue
// Initiator side of the multi-cycle divider handshake in the EX stage.
// Latches DIV/DIVU operands, drives the divider start/annul/signed
// controls, stalls the pipeline while the divide runs, and owns the
// architectural HI/LO registers. A divide result reaches HI/LO only when
// the issuing instruction leaves EX without being flushed.
//
// Handshake: div_start is a level request. It rises the edge after a
// request is accepted in IDLE and stays high until div_ready (result
// valid) or flush is sampled in BUSY. It is then held low for at least one
// full cycle (DRAIN or HOLD) so the divider returns to free before the
// next request.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   flush, pipe_hold         pipeline squash / EX cannot advance
//   div_req, div_signed_i    DIV/DIVU valid in EX, 1 = signed
//   rs_data, rt_data         dividend, divisor
//   div_ready, div_result    divider result valid, {rem, quot}
//   div_start, div_annul     divider request (registered) / abort (comb)
//   div_signed               divider signed control (registered)
//   div_op1, div_op2         divider operands (registered)
//   ex_stall                 combinational stall request
//   wb_hi_we/wdata, wb_lo_we/wdata   MTHI/MTLO/MULT writes
//   hi_o, lo_o               current HI/LO
//   dbg_state                FSM state (IDLE=0 BUSY=1 HOLD=2 DRAIN=3)
module div_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        pipe_hold,
  input  logic        div_req,
  input  logic        div_signed_i,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        ex_stall,
  input  logic        wb_hi_we,
  input  logic        wb_lo_we,
  input  logic [31:0] wb_hi_wdata,
  input  logic [31:0] wb_lo_wdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_start;
  logic        r_signed;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [63:0] r_buf;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_commit;
  logic [63:0] w_commit_data;

  // A divide commits when its instruction leaves EX un-flushed: either
  // straight from BUSY on the ready cycle, or later from the HOLD buffer.
  assign w_commit = !flush && !pipe_hold &&
                    (((r_state == BUSY) && div_ready) || (r_state == HOLD));
  assign w_commit_data = (r_state == HOLD) ? r_buf : div_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_start  <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_buf    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_req && !flush) begin
            r_op1    <= rs_data;
            r_op2    <= rt_data;
            r_signed <= div_signed_i;
            r_start  <= 1'b1;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          // Flush wins over a same-cycle ready: the result is dropped.
          if (flush) begin
            r_start <= 1'b0;
            r_state <= DRAIN;
          end else if (div_ready) begin
            r_buf   <= div_result;
            r_start <= 1'b0;
            r_state <= pipe_hold ? HOLD : DRAIN;
          end
        end
        HOLD: begin
          // div_req here still belongs to the finished instruction.
          if (flush || !pipe_hold) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The divide is younger than any same-cycle MTHI/MTLO/MULT write, so its
  // commit takes priority on both halves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_commit_data[63:32];
      r_lo <= w_commit_data[31:0];
    end else begin
      if (wb_hi_we) r_hi <= wb_hi_wdata;
      if (wb_lo_we) r_lo <= wb_lo_wdata;
    end
  end

  assign div_annul  = (r_state == BUSY) && flush;
  assign ex_stall   = !flush && (((r_state == IDLE)  && div_req) ||
                                 ((r_state == BUSY)  && !div_ready) ||
                                 ((r_state == DRAIN) && div_req));
  assign div_start  = r_start;
  assign div_signed = r_signed;
  assign div_op1    = r_op1;
  assign div_op2    = r_op2;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_div_issue.sv
`timescale 1ns/1ps
module tb_div_issue;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        pipe_hold;
  logic        div_req;
  logic        div_signed_i;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        div_ready;
  logic [63:0] div_result;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        ex_stall;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_hi_wdata;
  logic [31:0] wb_lo_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] prev_hilo;
  bit          mon_en;

  div_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .pipe_hold(pipe_hold),
    .div_req(div_req), .div_signed_i(div_signed_i),
    .rs_data(rs_data), .rt_data(rt_data),
    .div_ready(div_ready), .div_result(div_result),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .ex_stall(ex_stall),
    .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
    .wb_hi_wdata(wb_hi_wdata), .wb_lo_wdata(wb_lo_wdata),
    .hi_o(hi_o), .lo_o(lo_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
    m_hi = hi;
    m_lo = lo;
    exp_q.push_back({hi, lo});
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every visible HI/LO change must match the oldest expected commit.
  always @(negedge clk) begin
    if (mon_en && ({hi_o, lo_o} !== prev_hilo)) begin
      if (exp_q.size() == 0) begin
        chk("hilo_unexpected_write", {hi_o, lo_o}, prev_hilo);
      end else begin
        chk("hilo_commit", {hi_o, lo_o}, exp_q.pop_front());
      end
      prev_hilo = {hi_o, lo_o};
    end
  end

  // ---------------- driver tasks ----------------
  // One divide from request to leaving EX. Ends #1 after the commit (or
  // HOLD exit) edge with div_req low.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] res,
                        input int hold_cyc, input bit hold_flush, input bit wb_clash);
    div_req = 1'b1; div_signed_i = sgn; rs_data = a; rt_data = b;
    #1;
    if (dbg_state == S_DRAIN) begin
      chk("drain_stall", ex_stall, 1);
      chk("drain_start_low", div_start, 0);
      tick();
    end
    chk("idle_state", dbg_state, S_IDLE);
    chk("idle_stall", ex_stall, 1);
    chk("idle_start_low", div_start, 0);
    tick();
    chk("busy_state", dbg_state, S_BUSY);
    chk("busy_start", div_start, 1);
    chk("busy_op1", div_op1, a);
    chk("busy_op2", div_op2, b);
    chk("busy_signed", div_signed, sgn);
    rs_data = ~a; rt_data = ~b; div_signed_i = ~sgn;
    for (int i = 1; i < lat; i++) begin
      chk("busy_stall", ex_stall, 1);
      tick();
    end
    chk("busy_op1_held", div_op1, a);
    chk("busy_start_held", div_start, 1);
    div_ready = 1'b1; div_result = res; pipe_hold = (hold_cyc > 0);
    if (wb_clash) begin
      wb_lo_we = 1'b1; wb_lo_wdata = 32'hAAAA0000;
    end
    #1;
    chk("ready_stall_low", ex_stall, 0);
    if (hold_cyc == 0) push_exp(res[63:32], res[31:0]);
    tick();
    div_ready = 1'b0; div_result = '0; wb_lo_we = 1'b0;
    if (hold_cyc == 0) begin
      div_req = 1'b0;
      #1;
      chk("post_ready_drain", dbg_state, S_DRAIN);
      chk("post_ready_start_low", div_start, 0);
      return;
    end
    chk("hold_state", dbg_state, S_HOLD);
    chk("hold_start_low", div_start, 0);
    for (int i = 0; i < hold_cyc; i++) begin
      chk("hold_stall_low", ex_stall, 0);
      chk("hold_no_reissue", dbg_state, S_HOLD);
      tick();
    end
    if (hold_flush) flush = 1'b1;
    else begin
      pipe_hold = 1'b0;
      push_exp(res[63:32], res[31:0]);
    end
    tick();
    flush = 1'b0; pipe_hold = 1'b0; div_req = 1'b0;
    #1;
    chk("hold_exit_idle", dbg_state, S_IDLE);
    chk("hold_exit_start_low", div_start, 0);
  endtask

  // Issue a divide, flush it 10 cycles into BUSY (optionally with a
  // same-cycle div_ready carrying a result that must be dropped).
  task automatic flush_busy(input bit with_ready);
    div_req = 1'b1; div_signed_i = 1'b1; rs_data = 32'd77; rt_data = 32'd5;
    #1;
    if (dbg_state == S_DRAIN) tick();
    tick();
    chk("fl_busy_state", dbg_state, S_BUSY);
    for (int i = 0; i < 9; i++) begin
      chk("fl_annul_low", div_annul, 0);
      tick();
    end
    flush = 1'b1;
    if (with_ready) begin
      div_ready = 1'b1; div_result = 64'hDEADBEEF_CAFEF00D;
    end
    #1;
    chk("fl_annul_high", div_annul, 1);
    chk("fl_stall_low", ex_stall, 0);
    tick();
    flush = 1'b0; div_ready = 1'b0; div_result = '0; div_req = 1'b0;
    #1;
    chk("fl_annul_one_cycle", div_annul, 0);
    chk("fl_drain", dbg_state, S_DRAIN);
    chk("fl_start_low", div_start, 0);
    tick();
    chk("fl_idle", dbg_state, S_IDLE);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b0; flush = 1'b0; pipe_hold = 1'b0; div_req = 1'b0;
    div_signed_i = 1'b0; rs_data = '0; rt_data = '0;
    div_ready = 1'b0; div_result = '0;
    wb_hi_we = 1'b0; wb_lo_we = 1'b0; wb_hi_wdata = '0; wb_lo_wdata = '0;
    m_hi = '0; m_lo = '0; prev_hilo = '0; mon_en = 1'b0;

    repeat (3) tick();
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_start", div_start, 0);
    chk("rst_signed", div_signed, 0);
    chk("rst_op1", div_op1, 0);
    chk("rst_op2", div_op2, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_stall", ex_stall, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // Signed 100/7 = 14 r 2, nominal latency.
    do_div(1'b1, 32'd100, 32'd7, 35, {32'd2, 32'd14}, 0, 1'b0, 1'b0);
    tick();
    // Signed -7/2 = -3 r -1.
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 5, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b0, 1'b0);
    tick();
    // Unsigned 0xFFFFFFFF/2, minimum latency.
    do_div(1'b0, 32'hFFFFFFFF, 32'd2, 1, {32'h00000001, 32'h7FFFFFFF}, 0, 1'b0, 1'b0);
    tick();

    flush_busy(1'b0);
    flush_busy(1'b1);

    // pipe_hold at ready: 45/6 = 7 r 3 commits when hold drops.
    do_div(1'b1, 32'd45, 32'd6, 4, {32'd3, 32'd7}, 3, 1'b0, 1'b0);
    tick();
    // Same, but flushed while in HOLD: no write.
    do_div(1'b1, 32'd99, 32'd10, 4, {32'd9, 32'd9}, 2, 1'b1, 1'b0);
    tick();

    // Back-to-back: 20/3 = 6 r 2 then 9/4 = 2 r 1.
    do_div(1'b1, 32'd20, 32'd3, 6, {32'd2, 32'd6}, 0, 1'b0, 1'b0);
    do_div(1'b1, 32'd9, 32'd4, 6, {32'd1, 32'd2}, 0, 1'b0, 1'b0);
    tick();

    // wb_lo_we collides with commit: 15/4 = 3 r 3, LO takes the quotient.
    do_div(1'b0, 32'd15, 32'd4, 3, {32'd3, 32'd3}, 0, 1'b0, 1'b1);
    tick();

    // wb_hi_we alone in IDLE.
    wb_hi_we = 1'b1; wb_hi_wdata = 32'h12345678;
    push_exp(32'h12345678, m_lo);
    tick();
    wb_hi_we = 1'b0;
    tick();

    // Reset mid-BUSY clears everything at once.
    div_req = 1'b1; div_signed_i = 1'b1; rs_data = 32'd50; rt_data = 32'd3;
    tick();
    tick();
    chk("mid_busy_state", dbg_state, S_BUSY);
    push_exp(32'd0, 32'd0);
    rst = 1'b0; div_req = 1'b0;
    #1;
    chk("mid_rst_state", dbg_state, S_IDLE);
    chk("mid_rst_start", div_start, 0);
    chk("mid_rst_op1", div_op1, 0);
    chk("mid_rst_hi", hi_o, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
